uart_rx_core: RTL and testbench

//  Receive side of the UART link. Consumes the serial line driven by the TX path's TX_OUT.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 76 +++++++
 rtl/uart_rx_core.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   PAR_EVEN / PAR_ODD : meaning of the PAR_TYP input
//   majority3  : 2-of-3 vote used on the oversampled line
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Line conditioning for the UART receiver: 2-flop synchroniser, per-bit
// oversampling counter and a 3-point majority vote around the bit centre.
// Ports:
//   clk, rst  : oversampling clock, asynchronous active-high reset
//   rx_in     : raw serial line (idle high)
//   clr       : holds the oversampling counter at 0 (driven by the FSM)
//   rx_s      : synchronised line
//   sample    : majority of rx_s at counts OVS/2-1, OVS/2, OVS/2+1;
//               stable from count OVS/2+2 until the next bit centre
//   bit_end   : counter is at OVS-1 (last clock of the current bit)
// ----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic clr,
    output logic rx_s,
    output logic sample,
    output logic bit_end
);

    localparam int            CW     = $clog2(OVS);
    localparam logic [CW-1:0] LAST   = CW'(OVS - 1);
    localparam logic [CW-1:0] MID_LO = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] MID    = CW'(OVS / 2);
    localparam logic [CW-1:0] MID_HI = CW'(OVS / 2 + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] edge_cnt;
    logic [2:0]    votes;

    // Synchroniser stages reset to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx_in;
            sync_p1 <= sync_p0;
        end
    end

    assign rx_s = sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (clr || edge_cnt == LAST) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + CW'(1);
        end
    end

    // Vote capture at the three centre points of the bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            votes <= 3'b111;
        end else begin
            if (edge_cnt == MID_LO) votes[0] <= rx_s;
            if (edge_cnt == MID)    votes[1] <= rx_s;
            if (edge_cnt == MID_HI) votes[2] <= rx_s;
        end
    end

    assign sample  = majority3(votes);
    assign bit_end = (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: recovers start / WIDTH data bits (LSB first) / optional
// parity / stop frames from an OVS-times oversampled serial line.
// Ports:
//   CLK_RX, RST_RX : oversampling clock, asynchronous active-high reset
//   RX_IN          : serial line, idle high
//   PAR_EN         : parity bit present (latched at start of each frame)
//   PAR_TYP        : 0 even, 1 odd (latched at start of each frame)
//   P_DATA_RX      : last good word, held until the next good frame
//   DATA_VALID_RX  : 1-cycle pulse, P_DATA_RX updated
//   PAR_ERR        : 1-cycle pulse, parity mismatch
//   STP_ERR        : 1-cycle pulse, stop bit sampled 0
//   BREAK_DET      : 1-cycle pulse, break frame seen (UART_RX_BREAK_DET_EN only)
// Build option UART_RX_BREAK_DET_EN: all-zero frame with zero stop bit is
// reported as BREAK_DET and the receiver waits for OVS clocks of idle line.
// ----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OVS   = 8
) (
    input  logic             CLK_RX,
    input  logic             RST_RX,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA_RX,
    output logic             DATA_VALID_RX,
    output logic             PAR_ERR,
    output logic             STP_ERR
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic             BREAK_DET
`endif
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             rx_s;
    logic             sample;
    logic             bit_end;
    logic             edge_clr;

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             par_en_l;
    logic             par_typ_l;
    logic             par_bad;

    logic             ld_cfg;
    logic             shift_en;
    logic             chk_par;
    logic             fin;

`ifdef UART_RX_BREAK_DET_EN
    logic             par_bit;
    logic             is_break;

    // Break: all data zero, parity bit (if any) zero and stop bit zero
    assign is_break = (shift_reg == '0) && !par_bit && !sample;
`endif

    uart_rx_sampler #(
        .OVS     (OVS)
    ) u_sampler (
        .clk     (CLK_RX),
        .rst     (RST_RX),
        .rx_in   (RX_IN),
        .clr     (edge_clr),
        .rx_s    (rx_s),
        .sample  (sample),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK_RX or posedge RST_RX) begin
        if (RST_RX) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The edge counter is held at 0 while the line is idle so that the cycle
    // in which the start bit is first seen is count 0 of the start bit; this
    // keeps back-to-back frames from drifting against the bit grid.
    always_comb begin
        state_nxt = state;
        edge_clr  = 1'b0;
        ld_cfg    = 1'b0;
        shift_en  = 1'b0;
        chk_par   = 1'b0;
        fin       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    ld_cfg    = 1'b1;
                end else begin
                    edge_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_nxt = sample ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BCW'(WIDTH - 1)) state_nxt = par_en_l ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    chk_par   = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    fin       = 1'b1;
                    state_nxt = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                    if (is_break) state_nxt = ST_BREAK_WAIT;
`endif
                end
            end
            ST_BREAK_WAIT: begin
                // Any low clock restarts the OVS-clock idle qualification
                if (!rx_s) begin
                    edge_clr  = 1'b1;
                end else if (bit_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame control and output pulse stage
    always_ff @(posedge CLK_RX or posedge RST_RX) begin
        if (RST_RX) begin
            bit_cnt       <= '0;
            par_en_l      <= 1'b0;
            par_typ_l     <= 1'b0;
            par_bad       <= 1'b0;
            P_DATA_RX     <= '0;
            DATA_VALID_RX <= 1'b0;
            PAR_ERR       <= 1'b0;
            STP_ERR       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit       <= 1'b0;
            BREAK_DET     <= 1'b0;
`endif
        end else begin
            DATA_VALID_RX <= 1'b0;
            PAR_ERR       <= 1'b0;
            STP_ERR       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            BREAK_DET     <= 1'b0;
`endif
            if (ld_cfg) begin
                bit_cnt   <= '0;
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_bad   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                par_bit   <= 1'b0;
`endif
            end
            if (shift_en) bit_cnt <= bit_cnt + BCW'(1);
            if (chk_par) begin
                par_bad <= sample ^ (^shift_reg) ^ (par_typ_l == PAR_ODD);
`ifdef UART_RX_BREAK_DET_EN
                par_bit <= sample;
`endif
            end
            if (fin) begin
`ifdef UART_RX_BREAK_DET_EN
                if (is_break) begin
                    BREAK_DET <= 1'b1;
                end else begin
                    STP_ERR <= !sample;
                    PAR_ERR <= par_bad;
                    if (sample && !par_bad) begin
                        DATA_VALID_RX <= 1'b1;
                        P_DATA_RX     <= shift_reg;
                    end
                end
`else
                STP_ERR <= !sample;
                PAR_ERR <= par_bad;
                if (sample && !par_bad) begin
                    DATA_VALID_RX <= 1'b1;
                    P_DATA_RX     <= shift_reg;
                end
`endif
            end
        end
    end

    // Data shift register: bits arrive LSB first, so shift in from the top
    always_ff @(posedge CLK_RX) begin
        if (shift_en) shift_reg <= {sample, shift_reg[WIDTH-1:1]};
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Bench for uart_rx_core (WIDTH=8, OVS=8). Frames are driven one bit per OVS
// clocks; a frame-level model predicts, for each frame, which pulse must
// appear, on which clock, and with which word. A monitor compares every
// clock against that prediction.
// ----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int WIDTH = 8;
    localparam int OVS   = 8;

    logic             CLK_RX  = 1'b0;
    logic             RST_RX  = 1'b1;
    logic             RX_IN   = 1'b1;
    logic             PAR_EN  = 1'b0;
    logic             PAR_TYP = 1'b0;
    logic [WIDTH-1:0] P_DATA_RX;
    logic             DATA_VALID_RX;
    logic             PAR_ERR;
    logic             STP_ERR;
    logic             brk_o;

`ifdef UART_RX_BREAK_DET_EN
    logic BREAK_DET;
    assign brk_o = BREAK_DET;
`else
    assign brk_o = 1'b0;
`endif

    uart_rx_core #(
        .WIDTH         (WIDTH),
        .OVS           (OVS)
    ) dut (
        .CLK_RX        (CLK_RX),
        .RST_RX        (RST_RX),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .P_DATA_RX     (P_DATA_RX),
        .DATA_VALID_RX (DATA_VALID_RX),
        .PAR_ERR       (PAR_ERR),
        .STP_ERR       (STP_ERR)
`ifdef UART_RX_BREAK_DET_EN
        ,
        .BREAK_DET     (BREAK_DET)
`endif
    );

    always #5 CLK_RX = ~CLK_RX;

    int cyc = 0;
    always @(posedge CLK_RX) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected pulse queue: written by the stimulus, consumed by the monitor
    int              exp_cyc [256];
    logic            exp_v   [256];
    logic            exp_p   [256];
    logic            exp_s   [256];
    logic            exp_b   [256];
    logic [WIDTH-1:0] exp_d  [256];
    int wr = 0;
    int rd = 0;

    logic [WIDTH-1:0] last_good = '0;
    int n_valid = 0, n_par = 0, n_stp = 0, n_brk = 0;
    int vcyc_prev = 0, vcyc_last = 0;

    task automatic push_exp(input int c, input logic v, input logic p, input logic s,
                            input logic b, input logic [WIDTH-1:0] d);
        exp_cyc[wr] = c;
        exp_v[wr]   = v;
        exp_p[wr]   = p;
        exp_s[wr]   = s;
        exp_b[wr]   = b;
        exp_d[wr]   = d;
        wr = wr + 1;
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (OVS) @(negedge CLK_RX);
    endtask

    // Predicts the outcome of one frame, then drives it. The pulse lands
    // 2 synchroniser clocks plus one full frame after the start bit is driven.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input int gap_bits);
        int   nb;
        logic v, p, s, b;
        nb = pe ? WIDTH + 3 : WIDTH + 2;
        p  = pe && (pbit != ((^d) ^ pt));
        s  = !sbit;
        b  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        if (d == '0 && (!pe || !pbit) && !sbit) begin
            b = 1'b1;
            p = 1'b0;
            s = 1'b0;
        end
`endif
        v = !p && !s && !b;
        push_exp(cyc + 2 + nb * OVS, v, p, s, b, d);
        PAR_EN  = pe;
        PAR_TYP = pt;
        drive_bit(1'b0);
        // Mid-frame configuration changes must have no effect
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(sbit);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (rd != wr && n < 3000) begin
            @(negedge CLK_RX);
            n++;
        end
        repeat (2) @(negedge CLK_RX);
        chk("queue_drained", rd, wr);
    endtask

    // Monitor: every clock, away from the active edge
    always @(posedge CLK_RX) begin
        #1;
        if (RST_RX) begin
            rd        = wr;
            last_good = '0;
        end else begin
            if (DATA_VALID_RX) begin
                n_valid   = n_valid + 1;
                vcyc_prev = vcyc_last;
                vcyc_last = cyc;
            end
            if (PAR_ERR) n_par = n_par + 1;
            if (STP_ERR) n_stp = n_stp + 1;
            if (brk_o)   n_brk = n_brk + 1;
            if (DATA_VALID_RX || PAR_ERR || STP_ERR || brk_o) begin
                checks = checks + 1;
                if (rd == wr) begin
                    errors = errors + 1;
                    $display("FAIL unexpected_pulse: v/p/s/b=%b%b%b%b at cycle %0d, expected none",
                             DATA_VALID_RX, PAR_ERR, STP_ERR, brk_o, cyc);
                end else begin
                    if ({DATA_VALID_RX, PAR_ERR, STP_ERR, brk_o} !==
                            {exp_v[rd], exp_p[rd], exp_s[rd], exp_b[rd]} ||
                        cyc < exp_cyc[rd] - 1 || cyc > exp_cyc[rd] + 1) begin
                        errors = errors + 1;
                        $display("FAIL pulse: v/p/s/b=%b%b%b%b at cycle %0d, expected %b%b%b%b at cycle %0d",
                                 DATA_VALID_RX, PAR_ERR, STP_ERR, brk_o, cyc,
                                 exp_v[rd], exp_p[rd], exp_s[rd], exp_b[rd], exp_cyc[rd]);
                    end
                    if (exp_v[rd]) begin
                        checks = checks + 1;
                        if (P_DATA_RX !== exp_d[rd]) begin
                            errors = errors + 1;
                            $display("FAIL rx_word: got %0h, expected %0h", P_DATA_RX, exp_d[rd]);
                        end
                        last_good = exp_d[rd];
                    end
                    rd = rd + 1;
                end
            end else if (rd != wr && cyc > exp_cyc[rd] + 1) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL missing_pulse: none by cycle %0d, expected v/p/s/b=%b%b%b%b at cycle %0d",
                         cyc, exp_v[rd], exp_p[rd], exp_s[rd], exp_b[rd], exp_cyc[rd]);
                rd = rd + 1;
            end
            checks = checks + 1;
            if (P_DATA_RX !== last_good) begin
                errors = errors + 1;
                $display("FAIL data_hold: got %0h, expected %0h at cycle %0d", P_DATA_RX, last_good, cyc);
                last_good = P_DATA_RX;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, p0, s0, b0, m;

        // Reset state
        repeat (3) @(negedge CLK_RX);
        chk("reset_data",  P_DATA_RX,     0);
        chk("reset_valid", DATA_VALID_RX, 0);
        chk("reset_perr",  PAR_ERR,       0);
        chk("reset_serr",  STP_ERR,       0);
        chk("reset_brk",   brk_o,         0);
        RST_RX = 1'b0;
        repeat (2 * OVS) @(negedge CLK_RX);

        // 1: no parity, 0xA5
        v0 = n_valid; p0 = n_par; s0 = n_stp;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        wait_drain();
        chk("t1_data",  P_DATA_RX, 8'hA5);
        chk("t1_valid", n_valid - v0, 1);
        chk("t1_errs",  (n_par - p0) + (n_stp - s0), 0);

        // 2: even parity 0x3C, good then bad parity
        v0 = n_valid; p0 = n_par; s0 = n_stp;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        wait_drain();
        chk("t2_data",  P_DATA_RX, 8'h3C);
        chk("t2_valid", n_valid - v0, 1);
        chk("t2_perr",  n_par - p0, 1);
        chk("t2_serr",  n_stp - s0, 0);

        // 3: odd parity 0x01, correct parity, stop forced low
        v0 = n_valid; p0 = n_par; s0 = n_stp;
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        wait_drain();
        chk("t3_serr",  n_stp - s0, 1);
        chk("t3_valid", n_valid - v0, 0);
        chk("t3_perr",  n_par - p0, 0);
        chk("t3_data",  P_DATA_RX, 8'h3C);

        // 4: 3-clock glitch on the line
        v0 = n_valid; p0 = n_par; s0 = n_stp; b0 = n_brk;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK_RX);
        RX_IN = 1'b1;
        repeat (3 * OVS) @(negedge CLK_RX);
        chk("t4_pulses", (n_valid - v0) + (n_par - p0) + (n_stp - s0) + (n_brk - b0), 0);

        // 5: back-to-back 0x55, 0xFF
        v0 = n_valid;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        wait_drain();
        chk("t5_valid", n_valid - v0, 2);
        chk("t5_data",  P_DATA_RX, 8'hFF);
        chk("t5_spacing", int'((vcyc_last - vcyc_prev) >= 79 && (vcyc_last - vcyc_prev) <= 81), 1);

        // 6: reset in the middle of data bit 4, then a clean 0x7E
        PAR_EN = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX_IN = 1'b0;
        repeat (OVS / 2) @(negedge CLK_RX);
        RST_RX = 1'b1;
        #1;
        chk("t6_rst_data",  P_DATA_RX,     0);
        chk("t6_rst_valid", DATA_VALID_RX, 0);
        chk("t6_rst_serr",  STP_ERR,       0);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK_RX);
        RST_RX = 1'b0;
        repeat (2 * OVS) @(negedge CLK_RX);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        wait_drain();
        chk("t6_data", P_DATA_RX, 8'h7E);

        // Line held low for 30 bit times
        v0 = n_valid; s0 = n_stp; b0 = n_brk;
        PAR_EN = 1'b0;
        m = cyc;
`ifdef UART_RX_BREAK_DET_EN
        push_exp(m + 2 + 10 * OVS, 1'b0, 1'b0, 1'b0, 1'b1, '0);
`else
        for (int k = 1; k <= 3; k++) push_exp(m + 2 + 10 * OVS * k, 1'b0, 1'b0, 1'b1, 1'b0, '0);
`endif
        RX_IN = 1'b0;
        repeat (30 * OVS) @(negedge CLK_RX);
        RX_IN = 1'b1;
        repeat (3 * OVS) @(negedge CLK_RX);
        wait_drain();
        chk("low_valid", n_valid - v0, 0);
`ifdef UART_RX_BREAK_DET_EN
        chk("low_brk",  n_brk - b0, 1);
        chk("low_serr", n_stp - s0, 0);
`else
        chk("low_serr", n_stp - s0, 3);
        chk("low_brk",  n_brk - b0, 0);
`endif

        // Randomised frames
        for (int n = 0; n < 24; n++) begin
            logic [WIDTH-1:0] d;
            logic pe, pt, pbit, sbit;
            int   gap;
            d    = ($urandom_range(0, 6) == 0) ? '0 : WIDTH'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            pbit = (^d) ^ pt;
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            sbit = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            if (!sbit && gap < 2) gap = 2;
            send_frame(d, pe, pt, pbit, sbit, gap);
        end
        drive_bit(1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
